// File: rtl/dm_lsu_pkg.sv
// dm_lsu_pkg: shared types, size constants and lane helpers for the load/store unit.
package dm_lsu_pkg;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPLIT = 2'd1,
      RESP2 = 2'd2
   } state_e;

   localparam logic [2:0] SIZE_B = 3'd1;
   localparam logic [2:0] SIZE_H = 3'd2;
   localparam logic [2:0] SIZE_W = 3'd4;

   // Access size in bytes; unused funct3 codes behave as a full word.
   function automatic logic [2:0] size_of(input logic [2:0] funct3);
      case (funct3)
         F3_LB, F3_LBU: return SIZE_B;
         F3_LH, F3_LHU: return SIZE_H;
         default:       return SIZE_W;
      endcase
   endfunction

   // True when the access spills past the end of its word.
   function automatic logic misaligned(input logic [1:0] off, input logic [2:0] size);
      return ({1'b0, off} + size) > 3'd4;
   endfunction

   // Byte-lane mask across a two-word window: [3:0] low word, [7:4] next word.
   function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [2:0] size);
      logic [7:0] base;
      case (size)
         SIZE_B:  base = 8'h01;
         SIZE_H:  base = 8'h03;
         default: base = 8'h0f;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/dm_lsu_extract.sv
// dm_lsu_extract: aligns a byte window out of two words and sign/zero-extends it.
module dm_lsu_extract
   import dm_lsu_pkg::*;
(
   input  logic [63:0] pair,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);

   logic [63:0] shifted;

   assign shifted = pair >> {off, 3'b000};

   // Select the access width and extend to 32 bits.
   always_comb begin
      rdata = shifted[31:0];
      case (funct3)
         F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  rdata = {24'h000000, shifted[7:0]};
         F3_LHU:  rdata = {16'h0000, shifted[15:0]};
         default: rdata = shifted[31:0];
      endcase
   end

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: turns CPU byte/half/word accesses into SRAM word accesses,
// splitting misaligned ones into two consecutive words.
module dm_lsu
   import dm_lsu_pkg::*;
#(
   parameter int AW = 14,
   parameter int DW = 32
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [DW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          stall,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          sram_cs,
   output logic          sram_oe,
   output logic [3:0]    sram_web,
   output logic [AW-1:0] sram_a,
   output logic [DW-1:0] sram_di,
   input  logic [DW-1:0] sram_do
);

   state_e        state_reg, state_next;
   logic [2:0]    f3_reg;
   logic [1:0]    off_reg;
   logic          we_reg;
   logic [AW-1:0] word_reg;
   logic [3:0]    hi_mask_reg;
   logic [DW-1:0] hi_data_reg;
   logic [DW-1:0] lo_word_reg;
   logic          pend_reg;
   logic [DW-1:0] hold_reg;

   logic [1:0]      req_off;
   logic [2:0]      req_size;
   logic            req_mis;
   logic [7:0]      req_mask;
   logic [2*DW-1:0] req_wide;
   logic            accept;
   logic [2*DW-1:0] ext_pair;
   logic [DW-1:0]   ext_data;
   logic            addr_unused;

   assign req_off  = req_addr[1:0];
   assign req_size = size_of(req_funct3);
   assign req_mis  = misaligned(req_off, req_size);
   assign req_mask = lane_mask(req_off, req_size);
   assign req_wide = {{DW{1'b0}}, req_wdata} << {req_off, 3'b000};
   assign accept   = req_valid && (state_reg != SPLIT);

   // Upper address bits lie outside the SRAM and are intentionally ignored.
   assign addr_unused = ^req_addr[DW-1:AW+2];

   // Second-half loads combine the captured low word with the word now arriving.
   assign ext_pair  = (state_reg == RESP2) ? {sram_do, lo_word_reg} : {{DW{1'b0}}, sram_do};
   assign rsp_valid = pend_reg || (state_reg == RESP2);
   assign rsp_rdata = rsp_valid ? ext_data : hold_reg;

   dm_lsu_extract u_extract (
      .pair   (ext_pair),
      .off    (off_reg),
      .funct3 (f3_reg),
      .rdata  (ext_data)
   );

   // Next state and SRAM drive; reset forces every output to its idle value at once.
   always_comb begin
      state_next = state_reg;
      stall      = 1'b0;
      sram_cs    = 1'b0;
      sram_oe    = 1'b0;
      sram_web   = 4'hf;
      sram_a     = '0;
      sram_di    = '0;
      case (state_reg)
         SPLIT: begin
            stall   = 1'b1;
            sram_cs = 1'b1;
            sram_a  = word_reg + AW'(1);
            if (we_reg) begin
               sram_web   = ~hi_mask_reg;
               sram_di    = hi_data_reg;
               state_next = IDLE;
            end else begin
               sram_oe    = 1'b1;
               state_next = RESP2;
            end
         end
         default: begin
            state_next = IDLE;
            if (req_valid) begin
               sram_cs = 1'b1;
               sram_a  = req_addr[AW+1:2];
               sram_oe = !req_we;
               if (req_we) begin
                  sram_web = ~req_mask[3:0];
                  sram_di  = req_wide[DW-1:0];
               end
               if (req_mis) begin
                  stall      = 1'b1;
                  state_next = SPLIT;
               end
            end
         end
      endcase
      if (!rst) begin
         state_next = IDLE;
         stall      = 1'b0;
         sram_cs    = 1'b0;
         sram_oe    = 1'b0;
         sram_web   = 4'hf;
         sram_a     = '0;
         sram_di    = '0;
      end
   end

   // State register and pending-response flag for single-word loads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         pend_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         pend_reg  <= accept && !req_we && !req_mis;
      end
   end

   // Latch the accepted request so the second half and the response can use it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         f3_reg      <= '0;
         off_reg     <= '0;
         we_reg      <= 1'b0;
         word_reg    <= '0;
         hi_mask_reg <= '0;
         hi_data_reg <= '0;
      end else if (accept) begin
         f3_reg      <= req_funct3;
         off_reg     <= req_off;
         we_reg      <= req_we;
         word_reg    <= req_addr[AW+1:2];
         hi_mask_reg <= req_mask[7:4];
         hi_data_reg <= req_wide[2*DW-1:DW];
      end
   end

   // Capture the low word of a split load and remember the last response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lo_word_reg <= '0;
         hold_reg    <= '0;
      end else begin
         if (state_reg == SPLIT && !we_reg) lo_word_reg <= sram_do;
         if (rsp_valid) hold_reg <= ext_data;
      end
   end

endmodule

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Load/store unit between the CPU MEM stage and the data-memory SRAM wrapper (DM1), directly upstream of the SRAM.
- Converts RV32I byte/half/word loads and stores into SRAM word accesses with per-byte write enables.
- Sign/zero-extends load data.
- Splits misaligned accesses into two consecutive word accesses, stalling the CPU for the extra cycle.

Parameters:
- AW, 14, SRAM word-address width (16K words; word 0x3fff is the sim-end mailbox).
- DW, 32, data width; fixed at 32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- req_valid  in  1  CPU memory request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address; bits [AW+1:0] used.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  CPU must hold the request and pipeline.
- rsp_valid  out  1  load data valid.
- rsp_rdata  out  32  extended load data.
- sram_cs  out  1  chip select, active-high.
- sram_oe  out  1  output enable for reads.
- sram_web  out  4  per-byte write enable, active-low.
- sram_a  out  AW  word address.
- sram_di  out  32  write data, lane-aligned.
- sram_do  in  32  read data, valid one cycle after the address.

Behaviour:
- Reset (rst=0, any time, including mid-split):
  - State goes to IDLE. A pending second half is dropped.
  - stall=0, rsp_valid=0, rsp_rdata=0, sram_cs=0, sram_oe=0, sram_web=4'hf, sram_a=0, sram_di=0.
- Size: B=1 byte, H=2, W=4. Illegal funct3 (011/110/111) is treated as W.
- off = req_addr[1:0]. An access is misaligned when off+size > 4.
- States: IDLE, SPLIT, RESP2.
- IDLE, req_valid=1, aligned:
  - Drive sram_cs=1, sram_a=req_addr[AW+1:2] in the same cycle (combinational).
  - Load: sram_oe=1. Latch funct3/off. Next cycle rsp_valid=1 with the extended data. stall=0 (1-cycle latency, back-to-back requests allowed).
  - Store: sram_web[i]=0 for lanes off..off+size-1. sram_di = req_wdata << 8*off. Completes in the same cycle.
- IDLE, req_valid=1, misaligned:
  - stall=1 combinationally. Issue the low word (addr word w) with lanes off..3. Latch the request. Go to SPLIT.
- SPLIT:
  - stall=1. Issue word (w+1) mod 2^AW. Wraps 0x3fff→0x0000.
  - Store: high lanes 0..(off+size-5), data req_wdata >> 8*(4-off). Go to IDLE.
  - Load: capture sram_do as lo_word. Go to RESP2.
- RESP2:
  - rsp_valid=1, rsp_rdata = extend(({sram_do, lo_word} >> 8*off)[size]). stall=0.
  - A new request in this cycle is accepted as from IDLE.
- Extension: B/H sign-extend from bit 7/15. BU/HU zero-extend.
- rsp_valid is a single-cycle pulse. rsp_rdata holds its last value otherwise.
- While stall=1 the CPU holds req_*. The block ignores req_valid in SPLIT.
- A store of 32'hffffffff to word 0x3fff is an ordinary aligned SW; no special handling.

Decomposition:
- Package dm_lsu_pkg:
  - funct3 enum: LB/LH/LW/LBU/LHU.
  - State enum: IDLE/SPLIT/RESP2.
  - Constants: SIZE_B/H/W.
  - Function misaligned(off, size).
- One sub-module, dm_lsu_extract: combinational 64-bit shift, size select and sign/zero extension. Used for both aligned and split loads.

Test Plan:
- SW 0x12345678 @0x8000, then LW @0x8000 → web=0000, a=0x2000; next cycle rsp_rdata=0x12345678, stall never asserted.
- SB 0xAB @0x8003, then LB @0x8003 → web=0111, di=0xAB000000; LB rsp=0xFFFFFFAB, LBU rsp=0x000000AB.
- Word 0x2000=0x44332211, 0x2001=0x88776655; LW @0x8002 → stall high 2 cycles, a=0x2000 then 0x2001; rsp=0x66554433 one cycle later.
- SH 0xBEEF @0x0000FFFF → web=0111 at a=0x3fff, then web=1110 at a=0x0000 (wrap); LHU @0xFFFF returns 0x0000BEEF.
- Assert rst=0 during SPLIT of a misaligned SW → outputs go to reset values immediately; second half never written; word 0x2001 unchanged.
- Back-to-back aligned LW at 0x8000, 0x8004, 0x8008 on consecutive cycles → three consecutive rsp_valid pulses, correct data, stall=0 throughout.
